// File: rtl/i2c_target_regs.sv
// I2C target with a small byte-wide register file and auto-incrementing pointer.
// SCL/SDA are oversampled on CLK; SCL is never used as a clock.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREGS    = 4,
  parameter int         PTR_W    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  output logic [7:0]       loc_rdata,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] wr_addr,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK
  } state_t;

  // [0],[1] synchronizer, [2] history for edge detection; idle bus level is high
  logic [2:0] scl_sr, sda_sr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scl_sr <= '1;
      sda_sr <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      scl_sr <= {scl_sr[1:0], scl_i};
      sda_sr <= {sda_sr[1:0], sda_i};
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sr[1];
  assign sda_s     = sda_sr[1];
  assign scl_rise  = scl_s & ~scl_sr[2];
  assign scl_fall  = ~scl_s & scl_sr[2];
  assign start_det = scl_s & scl_sr[2] & sda_sr[2] & ~sda_s;
  assign stop_det  = scl_s & scl_sr[2] & ~sda_sr[2] & sda_s;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ack_on_q, ack_on_d;
  logic             rw_q, rw_d;
  logic             sda_oe_d, busy_d, wr_pulse_d, wr_en;
  logic [PTR_W-1:0] wr_addr_d;
  logic [7:0]       regs [NREGS];
  logic [7:0]       byte_in, rd_byte;

  assign byte_in   = {shift_q[6:0], sda_s};
  assign rd_byte   = regs[ptr_q];
  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      ack_on_q  <= 1'b0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      // NOTE: the register file is small and must read back as zero after reset, so it is reset in flops rather than inferred as RAM.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      ack_on_q  <= ack_on_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      wr_pulse  <= wr_pulse_d;
      wr_addr   <= wr_addr_d;
      if (wr_en) regs[ptr_q] <= byte_in;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    ack_on_d   = ack_on_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe;
    busy_d     = busy;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_en      = 1'b0;

    // Bus conditions take priority over any coincident SCL edge
    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      ack_on_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      ack_on_d = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              ack_on_d  = 1'b0;
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                  state_d = S_ADDR_ACK;
                end else begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = byte_in[PTR_W-1:0];
                state_d = S_PTR_ACK;
              end else begin
                wr_en      = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr_q;
                state_d    = S_WACK;
              end
            end
          end
        end
        // First SCL fall drives ACK, second fall releases it and moves on
        S_ADDR_ACK, S_PTR_ACK, S_WACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              if (state_q == S_ADDR_ACK) begin
                if (rw_q) begin
                  shift_d  = rd_byte;
                  sda_oe_d = ~rd_byte[7];
                  state_d  = S_RDATA;
                end else begin
                  state_d = S_PTR;
                end
              end else if (state_q == S_PTR_ACK) begin
                state_d = S_WDATA;
              end else begin
                ptr_d   = ptr_q + PTR_W'(1);
                state_d = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              ack_on_d  = 1'b0;
              state_d   = S_RACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d    = ptr_q + PTR_W'(1);
              ack_on_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else if (scl_fall && ack_on_q) begin
            ack_on_d  = 1'b0;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            state_d   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C controller plus a register-file
// model that predicts ACKs, read data, write strobes and pointer movement.
module tb_i2c_target_regs;
  localparam int NREGS = 4;
  localparam int PTR_W = 2;
  localparam int Q     = 6;   // CLKs per quarter SCL period

  typedef logic [7:0] bq_t[$];

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             scl_m = 1'b1;
  logic             sda_m = 1'b1;
  logic             sda_bus;
  logic             sda_oe;
  logic [PTR_W-1:0] loc_addr = '0;
  logic [7:0]       loc_rdata;
  logic             wr_pulse;
  logic [PTR_W-1:0] wr_addr;
  logic             busy;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h50), .NREGS(NREGS), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RST(RST), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata), .wr_pulse(wr_pulse),
    .wr_addr(wr_addr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_regs [NREGS];
  int         model_ptr = 0;
  int         wr_q[$];
  int         exp_wr[$];
  bit         oe_seen = 1'b0;

  always @(negedge CLK) begin
    if (wr_pulse) wr_q.push_back(int'(wr_addr));
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: observed no end of run, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    s = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  // Returns the bus level in the ACK slot: 0 means the target acknowledged
  task automatic send_byte(input logic [7:0] b, output logic ack_lvl);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack_lvl);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(nack, s);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      loc_addr = PTR_W'(i);
      #1;
      check($sformatf("%s reg%0d", tag, i), 32'(loc_rdata), 32'(model_regs[i]));
    end
  endtask

  task automatic check_wr(input string tag);
    check({tag, " wr_pulse count"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      check($sformatf("%s wr_addr#%0d", tag, i), wr_q[i], exp_wr[i]);
    wr_q.delete();
    exp_wr.delete();
  endtask

  // START, address+W, pointer byte, then data bytes; pointer wraps over NREGS
  task automatic do_write(input int p, input bq_t d, input bit do_stop, input string tag);
    logic a;
    bus_start();
    send_byte(8'hA0, a);
    check({tag, " addr ack"}, 32'(a), 0);
    send_byte(8'(p), a);
    check({tag, " ptr ack"}, 32'(a), 0);
    model_ptr = p % NREGS;
    foreach (d[i]) begin
      send_byte(d[i], a);
      check($sformatf("%s data%0d ack", tag, i), 32'(a), 0);
      model_regs[model_ptr] = d[i];
      exp_wr.push_back(model_ptr);
      model_ptr = (model_ptr + 1) % NREGS;
    end
    if (do_stop) bus_stop();
  endtask

  // Optional pointer phase, then (repeated) START and an n-byte read, NACK on the last
  task automatic do_read(input int set_ptr, input int n, input string tag);
    logic       a;
    logic [7:0] b;
    if (set_ptr >= 0) begin
      bq_t none;
      do_write(set_ptr, none, 1'b0, tag);
    end
    bus_start();
    send_byte(8'hA1, a);
    check({tag, " rd addr ack"}, 32'(a), 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, (i == n - 1));
      check($sformatf("%s rd byte%0d", tag, i), 32'(b), 32'(model_regs[model_ptr]));
      if (i < n - 1) model_ptr = (model_ptr + 1) % NREGS;
    end
    tick(Q);
    check({tag, " sda released after nack"}, 32'(sda_oe), 0);
    check({tag, " busy after nack"}, 32'(busy), 0);
    bus_stop();
  endtask

  initial begin
    logic a;
    logic s;
    bq_t  d;

    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;

    // Reset state
    tick(4);
    check("reset sda_oe", 32'(sda_oe), 0);
    check("reset wr_pulse", 32'(wr_pulse), 0);
    check("reset wr_addr", 32'(wr_addr), 0);
    check("reset busy", 32'(busy), 0);
    check_regs("reset");
    RST = 1'b0;
    tick(4);

    // Single write, busy held until STOP
    d = '{8'h3C};
    do_write(8'h01, d, 1'b0, "t1");
    check("t1 busy before stop", 32'(busy), 1);
    bus_stop();
    tick(Q);
    check("t1 busy after stop", 32'(busy), 0);
    check_wr("t1");
    check_regs("t1");

    // Write with pointer wrap 3 -> 0
    d = '{8'h11, 8'h22};
    do_write(8'h03, d, 1'b1, "t2");
    check_wr("t2");
    check_regs("t2");

    // Set up 0x5A/0xC3 at 2..3, then pointer write + repeated START + 2-byte read
    d = '{8'h5A, 8'hC3};
    do_write(8'h02, d, 1'b1, "t3w");
    check_wr("t3w");
    do_read(8'h02, 2, "t3");

    // Non-matching address: never ACKs, never drives SDA
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'hA4, a);
    check("t4 no ack", 32'(a), 1);
    send_byte(8'h01, a);
    check("t4 silent after mismatch", 32'(a), 1);
    check("t4 busy", 32'(busy), 0);
    bus_stop();
    tick(Q);
    check("t4 sda_oe never asserted", 32'(oe_seen), 0);
    check_wr("t4");
    check_regs("t4");

    // STOP in mid data byte aborts the write
    d = {};
    do_write(8'h00, d, 1'b0, "t5");
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
    bus_stop();
    tick(Q);
    check("t5 busy", 32'(busy), 0);
    check("t5 sda_oe", 32'(sda_oe), 0);
    check_wr("t5");
    check_regs("t5");

    // Randomized writes and reads against the model
    for (int it = 0; it < 8; it++) begin
      int n;
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = {};
        for (int k = 0; k < n; k++) d.push_back(8'($urandom));
        do_write(int'($urandom_range(0, 255)), d, 1'b1, $sformatf("rnd%0d w", it));
      end else begin
        do_read(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1, n,
                $sformatf("rnd%0d r", it));
      end
      check_wr($sformatf("rnd%0d", it));
    end
    check_regs("rnd");

    // Reset while the target is driving a 0 read bit
    d = '{8'h11};
    do_write(8'h00, d, 1'b1, "t6w");
    check_wr("t6w");
    d = {};
    do_write(8'h00, d, 1'b0, "t6");
    bus_start();
    send_byte(8'hA1, a);
    check("t6 rd addr ack", 32'(a), 0);
    check("t6 driving read bit 0", 32'(sda_oe), 1);
    #2 RST = 1'b1;
    #1;
    check("t6 async sda_oe drop", 32'(sda_oe), 0);
    check("t6 busy in reset", 32'(busy), 0);
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    check_regs("t6");
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    RST = 1'b0;
    tick(4);
    wr_q.delete();
    exp_wr.delete();

    // Pointer is back at 0 after reset: a bare read returns reg[0]
    do_read(-1, 1, "t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Downstream stage of the APB-I2C bridge: an I2C target (slave) that consumes the SCL/SDA traffic the bridge produces.
- Holds a small byte-wide register file. It supports addressed writes and reads with an auto-incrementing register pointer.
- Used as the on-chip loopback peer for bridge bring-up and verification. It also serves as a reusable target for I2C peripherals.
- Oversamples the bus on the system clock CLK. SCL is never used as a clock.

Parameters:
- DEV_ADDR, 7'h50, 7-bit I2C device address this target responds to.
- NREGS, 4, number of 8-bit registers (power of two, 2..256).
- PTR_W, 2, pointer width = log2(NREGS).

Ports:
- CLK  input  1  system clock; must be at least 8x the SCL frequency.
- RST  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pin level (read-only; clock stretching is not supported).
- sda_i  input  1  SDA pin level.
- sda_oe  output  1  1 = pull SDA low. The top level ties SDA to 1'bz otherwise (open drain).
- loc_addr  input  PTR_W  local-side register read address.
- loc_rdata  output  8  combinational read of reg[loc_addr].
- wr_pulse  output  1  one-CLK pulse when a byte has been written by I2C.
- wr_addr  output  PTR_W  register index of the last I2C write (valid with wr_pulse).
- busy  output  1  high from an addressed START until STOP or NACK.

Behaviour:
- Reset values: sda_oe=0, wr_pulse=0, wr_addr=0, busy=0, pointer=0, all registers=8'h00, state=IDLE.
- Input conditioning:
  - scl_i and sda_i pass through a 2-FF synchronizer plus a 1-FF history stage.
  - Edges are detected on the synchronized values. This gives 3-CLK input latency.
- Bus events:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Bits are sampled on the SCL rising edge.
  - SDA is changed only on the detected SCL falling edge.
- START handling (including repeated START): from any state, go to ADDR with bit counter 0.
- STOP handling: from any state, go to IDLE, release SDA, busy=0.
- States:
  - IDLE: ignore the bus; wait for START.
  - ADDR: shift in 8 bits MSB-first.
    - If [7:1]==DEV_ADDR: set busy=1 and go to ADDR_ACK.
    - Otherwise go to IDLE. Do not ACK; stay silent until the next START.
  - ADDR_ACK:
    - Assert sda_oe on the SCL fall after bit 8; release it on the next SCL fall.
    - If R/W=0, go to PTR.
    - If R/W=1, go to RDATA, loading shift=reg[pointer] at that falling edge.
  - PTR: shift in 8 bits; pointer <= byte[PTR_W-1:0] (upper bits ignored); then PTR_ACK.
  - PTR_ACK: ACK as above, then WDATA.
  - WDATA:
    - Shift in 8 bits.
    - At the 8th SCL rise: reg[pointer] <= byte, wr_pulse=1 for one CLK, wr_addr=pointer.
    - Then go to WACK.
  - WACK: ACK; pointer <= pointer+1 mod NREGS; back to WDATA.
  - RDATA:
    - Drive sda_oe = ~shift[7] from each SCL fall.
    - Shift left on each SCL rise.
    - Release SDA at the SCL fall after bit 8, then go to RACK.
  - RACK: sample SDA at the SCL rise.
    - 0 (ACK): pointer+1 mod NREGS; load the next byte at the SCL fall; go to RDATA.
    - 1 (NACK): busy=0; wait in IDLE for STOP or START.
- Boundary conditions:
  - The pointer wraps from NREGS-1 to 0 for both reads and writes.
  - A START or STOP in mid-byte aborts the byte. No register is written and no wr_pulse is produced.
  - Same-cycle conflict: if an SCL rise and a STOP/START detect coincide, the START/STOP wins.
  - Reset mid-transfer: sda_oe drops to 0 immediately (asynchronously).
  - The pointer persists across transactions. A read without a preceding PTR phase uses the last pointer.
  - loc_rdata reflects a write the CLK after the update.

Test Plan:
- Write 0xA0, ptr 0x01, data 0x3C, STOP -> ACK on all 3 bytes; reg[1]=0x3C; one wr_pulse with wr_addr=1; busy falls after STOP.
- Write ptr 0x03, data 0x11, 0x22 -> reg[3]=0x11, reg[0]=0x22 (wrap); two wr_pulses with wr_addr 3 then 0.
- Write 0xA0 ptr 0x02, repeated START, 0xA1, read 2 bytes (ACK, NACK) with reg[2]=0x5A and reg[3]=0xC3 -> SDA carries 0x5A then 0xC3; SDA released after the NACK.
- Address 0xA4 (7'h52) -> no ACK (sda_oe stays 0 throughout); registers unchanged; busy=0.
- START, 0xA0, ptr 0x00, 4 data bits then STOP -> reg[0] unchanged; no wr_pulse; state IDLE.
- RST asserted while driving a read bit 0 -> sda_oe=0 asynchronously; registers return to 0x00.
